// File: rtl/hsi_tx_arb_pkg.sv
// hsi_tx_arb_pkg: shared state encodings and default constants for the HSI transmit arbiter.
package hsi_tx_arb_pkg;
    typedef enum logic [1:0] {
        HSI_ARB_IDLE   = 2'd0,
        HSI_ARB_GRANT  = 2'd1,
        HSI_ARB_ACTIVE = 2'd2,
        HSI_ARB_GAP    = 2'd3
    } arb_state_e;
    localparam int HSI_ARB_GAP_CYC = 4;
    localparam int HSI_ARB_TO_CYC  = 1024;
    localparam int HSI_ARB_WD_W    = 16;
endpackage

// File: rtl/hsi_tx_arb_if.sv
// hsi_tx_arb_if: bundle between the frame sources, the arbiter and the byte serializer.
//   src_tx_rdy/src_tx_en      frame request level / one-cycle start pulse per source
//   src_d/src_d_rdy           per-source byte stream (byte i at bits [8i+7:8i])
//   src_d_sending             serializer busy level, routed back to the granted source only
//   ser_d/ser_d_rdy           byte stream towards the serializer
//   ser_d_sending             serializer is shifting the current byte
//   busy/grant_id             arbiter status
//   frame_done/timeout_err    one-cycle end-of-frame pulses
// master = arbiter side, slave = sources/serializer side.
interface hsi_tx_arb_if #(
    parameter int N_SRC = 3,
    parameter int ID_W  = 2
);
    logic [N_SRC-1:0]   src_tx_rdy;
    logic [N_SRC-1:0]   src_tx_en;
    logic [8*N_SRC-1:0] src_d;
    logic [N_SRC-1:0]   src_d_rdy;
    logic [N_SRC-1:0]   src_d_sending;
    logic [7:0]         ser_d;
    logic               ser_d_rdy;
    logic               ser_d_sending;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic               frame_done;
    logic               timeout_err;
    modport master (
        input  src_tx_rdy, src_d, src_d_rdy, ser_d_sending,
        output src_tx_en, src_d_sending, ser_d, ser_d_rdy, busy, grant_id, frame_done, timeout_err
    );
    modport slave (
        output src_tx_rdy, src_d, src_d_rdy, ser_d_sending,
        input  src_tx_en, src_d_sending, ser_d, ser_d_rdy, busy, grant_id, frame_done, timeout_err
    );
endinterface

// File: rtl/hsi_rr_pick.sv
// hsi_rr_pick: combinational round-robin picker.
//   req   request vector, one bit per source
//   last  index granted last time; the scan starts at last+1 with wrap
//   valid any request present
//   idx   first requesting index found by the scan
module hsi_rr_pick #(
    parameter int N_SRC = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);
    // Scan from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        valid = |req;
        idx = '0;
        for (int k = N_SRC; k >= 1; k--)
            if (req[(int'(last) + k) % N_SRC]) idx = ID_W'((int'(last) + k) % N_SRC);
    end
endmodule

// File: rtl/hsi_tx_arb.sv
// hsi_tx_arb: round-robin scheduler sharing one HSI byte serializer between N_SRC frame sources,
// with inter-frame gap and stall watchdog.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  hsi_tx_arb_if master: source requests/bytes in, grant pulses, serializer stream and status out
module hsi_tx_arb
    import hsi_tx_arb_pkg::*;
#(
    parameter int N_SRC   = 3,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = HSI_ARB_GAP_CYC,
    parameter int TO_CYC  = HSI_ARB_TO_CYC
) (
    input logic          clk,
    input logic          rst,
    hsi_tx_arb_if.master bus
);
    arb_state_e              state_q, state_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d, ptr_q, ptr_d, pick_idx;
    logic [N_SRC-1:0]        tx_en_q, tx_en_d;
    logic                    frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
    logic                    sending_q, pick_valid, rise, frame_end, active;
    logic [HSI_ARB_WD_W-1:0] wd_q, wd_d, wd_inc, gap_q, gap_d;

    hsi_rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
        .req   (bus.src_tx_rdy),
        .last  (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign active    = state_q == HSI_ARB_ACTIVE;
    assign rise      = bus.ser_d_sending & ~sending_q;
    assign frame_end = ~bus.src_tx_rdy[grant_id_q] & ~bus.ser_d_sending;
    assign wd_inc    = rise ? '0 : wd_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        tx_en_d       = '0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        wd_d          = wd_q;
        gap_d         = gap_q;
        case (state_q)
            HSI_ARB_IDLE: if (pick_valid) begin
                state_d    = HSI_ARB_GRANT;
                grant_id_d = pick_idx;
                ptr_d      = pick_idx;
                tx_en_d    = N_SRC'(1) << pick_idx;
            end
            HSI_ARB_GRANT: begin
                state_d = HSI_ARB_ACTIVE;
                wd_d    = '0;
            end
            HSI_ARB_ACTIVE: begin
                wd_d  = wd_inc;
                gap_d = '0;
                // Normal end has priority over a watchdog expiry in the same cycle.
                if (frame_end) begin
                    frame_done_d = 1'b1;
                    state_d      = GAP_CYC == 0 ? HSI_ARB_IDLE : HSI_ARB_GAP;
                end else if (TO_CYC != 0 && wd_inc == HSI_ARB_WD_W'(TO_CYC)) begin
                    timeout_err_d = 1'b1;
                    state_d       = GAP_CYC == 0 ? HSI_ARB_IDLE : HSI_ARB_GAP;
                end
            end
            HSI_ARB_GAP: begin
                gap_d   = gap_q + 16'd1;
                state_d = gap_q == HSI_ARB_WD_W'(GAP_CYC - 1) ? HSI_ARB_IDLE : HSI_ARB_GAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HSI_ARB_IDLE;
            grant_id_q    <= '0;
            ptr_q         <= ID_W'(N_SRC - 1);
            tx_en_q       <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
            gap_q         <= '0;
            sending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            tx_en_q       <= tx_en_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            sending_q     <= bus.ser_d_sending;
        end
    end

    assign bus.src_tx_en     = tx_en_q;
    assign bus.ser_d         = active ? bus.src_d[{grant_id_q, 3'b000} +: 8] : '0;
    assign bus.ser_d_rdy     = active & bus.src_d_rdy[grant_id_q];
    assign bus.src_d_sending = (active && bus.ser_d_sending) ? N_SRC'(1) << grant_id_q : '0;
    assign bus.busy          = state_q != HSI_ARB_IDLE;
    assign bus.grant_id      = grant_id_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_hsi_tx_arb.sv
// tb_hsi_tx_arb: randomized scenario bench for hsi_tx_arb with a round-robin reference model.
module tb_hsi_tx_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_a;

    always #5 clk = ~clk;

    hsi_tx_arb_if #(.N_SRC(3), .ID_W(2)) ia ();
    hsi_tx_arb_if #(.N_SRC(3), .ID_W(2)) ib ();

    hsi_tx_arb #(.N_SRC(3), .ID_W(2), .GAP_CYC(4), .TO_CYC(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    hsi_tx_arb #(.N_SRC(3), .ID_W(2), .GAP_CYC(0), .TO_CYC(0))  dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    function automatic int rr_next(input int last, input logic [2:0] m);
        for (int k = 1; k <= 3; k++) if (m[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ia.src_tx_rdy = '0; ia.src_d = '0; ia.src_d_rdy = '0; ia.ser_d_sending = 1'b0;
        ib.src_tx_rdy = '0; ib.src_d = '0; ib.src_d_rdy = '0; ib.ser_d_sending = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        last_a = 2;
    endtask

    task automatic wait_grant(input int g);
        for (int i = 0; i < 12 && ia.src_tx_en == '0; i++) step();
        n_cmp++;
        if (ia.src_tx_en !== 3'(1 << g) || ia.grant_id !== 2'(g)) begin
            n_bad++;
            $display("FAIL grant: tx_en=%b grant_id=%0d, want tx_en=%b grant_id=%0d", ia.src_tx_en, ia.grant_id, 3'(1 << g), g);
        end
        last_a = g;
    endtask

    task automatic finish_frame(input int g, input int nbytes, input bit iso);
        logic [7:0] v;
        step();
        n_cmp++;
        if (ia.src_tx_en !== 3'b000 || ia.busy !== 1'b1) begin
            n_bad++; $display("FAIL active_entry: tx_en=%b busy=%b, want 000/1", ia.src_tx_en, ia.busy);
        end
        for (int bi = 0; bi < nbytes; bi++) begin
            v = 8'($urandom);
            if (iso && v == 8'hAA) v = 8'h55;
            for (int s = 0; s < 3; s++) if (s != g) begin
                ia.src_d[8*s +: 8] = iso ? 8'hAA : 8'($urandom);
                ia.src_d_rdy[s] = 1'($urandom);
                if (iso) ia.src_tx_rdy[s] = 1'($urandom);
            end
            ia.src_d[8*g +: 8] = v;
            ia.src_d_rdy[g] = 1'b1;
            #1;
            n_cmp++;
            if (ia.ser_d !== v || ia.ser_d_rdy !== 1'b1) begin
                n_bad++; $display("FAIL ser_mux: ser_d=%h rdy=%b, want %h/1", ia.ser_d, ia.ser_d_rdy, v);
            end
            ia.ser_d_sending = 1'b1;
            #1;
            n_cmp++;
            if (ia.src_d_sending !== 3'(1 << g)) begin
                n_bad++; $display("FAIL sending_route: src_d_sending=%b, want %b", ia.src_d_sending, 3'(1 << g));
            end
            step();
            step();
            ia.ser_d_sending = 1'b0;
            ia.src_d_rdy[g] = 1'b0;
            #1;
            n_cmp++;
            if (ia.ser_d_rdy !== 1'b0 || ia.src_d_sending !== 3'b000) begin
                n_bad++; $display("FAIL idle_byte: ser_d_rdy=%b src_d_sending=%b, want 0/000", ia.ser_d_rdy, ia.src_d_sending);
            end
            step();
        end
        ia.src_tx_rdy[g] = 1'b0;
        step();
        n_cmp++;
        if (ia.frame_done !== 1'b1 || ia.timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL frame_done: frame_done=%b timeout_err=%b, want 1/0", ia.frame_done, ia.timeout_err);
        end
        step();
        n_cmp++;
        if (ia.frame_done !== 1'b0 || ia.busy !== 1'b1 || ia.ser_d !== 8'h00) begin
            n_bad++; $display("FAIL gap_entry: frame_done=%b busy=%b ser_d=%h, want 0/1/00", ia.frame_done, ia.busy, ia.ser_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        ia.src_tx_rdy = 3'b111;
        ia.ser_d_sending = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ia.src_tx_en, ia.busy, ia.grant_id, ia.frame_done, ia.timeout_err, ia.ser_d, ia.ser_d_rdy, ia.src_d_sending} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: tx_en=%b busy=%b gid=%0d fd=%b to=%b ser_d=%h rdy=%b snd=%b, want all 0",
                     ia.src_tx_en, ia.busy, ia.grant_id, ia.frame_done, ia.timeout_err, ia.ser_d, ia.ser_d_rdy, ia.src_d_sending);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        ia.src_tx_rdy = 3'b001;
        step();
        n_cmp++;
        if (ia.src_tx_en !== 3'b001 || ia.grant_id !== 2'd0 || ia.busy !== 1'b1) begin
            n_bad++; $display("FAIL single_latency: tx_en=%b gid=%0d busy=%b, want 001/0/1", ia.src_tx_en, ia.grant_id, ia.busy);
        end
        last_a = 0;
        finish_frame(0, 3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (ia.busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy: busy=%b, want 1", ia.busy); end
        end
        step();
        n_cmp++;
        if (ia.busy !== 1'b0 || ia.grant_id !== 2'd0) begin
            n_bad++; $display("FAIL gap_end: busy=%b gid=%0d, want 0/0", ia.busy, ia.grant_id);
        end
    endtask

    task automatic test_fairness();
        int prev;
        do_reset();
        prev = -1;
        for (int f = 0; f < 6; f++) begin
            ia.src_tx_rdy = 3'b111;
            wait_grant(f % 3);
            n_cmp++;
            if (int'(ia.grant_id) == prev) begin
                n_bad++; $display("FAIL fairness_repeat: grant_id=%0d equals previous %0d", ia.grant_id, prev);
            end
            prev = int'(ia.grant_id);
            finish_frame(f % 3, 2, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [2:0] m;
        int exp;
        for (int f = 0; f < 10; f++) begin
            m = 3'($urandom_range(1, 7));
            ia.src_tx_rdy = m;
            exp = rr_next(last_a, m);
            wait_grant(exp);
            finish_frame(exp, $urandom_range(1, 3), 1'b0);
        end
    endtask

    task automatic test_isolation();
        ia.src_tx_rdy = 3'b010;
        wait_grant(1);
        finish_frame(1, 3, 1'b1);
        ia.src_tx_rdy = '0;
        ia.src_d = '0;
        ia.src_d_rdy = '0;
    endtask

    task automatic test_watchdog();
        ia.src_tx_rdy = 3'b010;
        wait_grant(1);
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++;
            if (ia.timeout_err !== 1'b0 || ia.frame_done !== 1'b0 || ia.busy !== 1'b1) begin
                n_bad++; $display("FAIL wd_early: cycle %0d timeout_err=%b frame_done=%b busy=%b, want 0/0/1", i, ia.timeout_err, ia.frame_done, ia.busy);
            end
        end
        step();
        n_cmp++;
        if (ia.timeout_err !== 1'b1 || ia.frame_done !== 1'b0) begin
            n_bad++; $display("FAIL wd_fire: timeout_err=%b frame_done=%b, want 1/0", ia.timeout_err, ia.frame_done);
        end
        ia.src_tx_rdy = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (ia.src_tx_en !== 3'b000 || ia.timeout_err !== 1'b0) begin
                n_bad++; $display("FAIL wd_gap: cycle %0d tx_en=%b timeout_err=%b, want 000/0", i, ia.src_tx_en, ia.timeout_err);
            end
        end
        step();
        n_cmp++;
        if (ia.src_tx_en !== 3'b001 || ia.grant_id !== 2'd0) begin
            n_bad++; $display("FAIL wd_next: tx_en=%b gid=%0d, want 001/0", ia.src_tx_en, ia.grant_id);
        end
        last_a = 0;
        finish_frame(0, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int exp;
        ia.src_tx_rdy = 3'b111;
        exp = rr_next(last_a, 3'b111);
        wait_grant(exp);
        step();
        ia.src_d[8*exp +: 8] = 8'h11;
        ia.src_d_rdy[exp] = 1'b1;
        ia.ser_d_sending = 1'b1;
        step();
        step();
        ia.ser_d_sending = 1'b0;
        step();
        ia.src_d[8*exp +: 8] = 8'h22;
        ia.ser_d_sending = 1'b1;
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({ia.src_tx_en, ia.busy, ia.grant_id, ia.frame_done, ia.timeout_err, ia.ser_d, ia.ser_d_rdy, ia.src_d_sending} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: tx_en=%b busy=%b gid=%0d fd=%b to=%b ser_d=%h rdy=%b snd=%b, want all 0",
                     ia.src_tx_en, ia.busy, ia.grant_id, ia.frame_done, ia.timeout_err, ia.ser_d, ia.ser_d_rdy, ia.src_d_sending);
        end
        rst = 1'b0;
        clear_inputs();
        ia.src_tx_rdy = 3'b111;
        last_a = 2;
        step();
        n_cmp++;
        if (ia.src_tx_en !== 3'b001 || ia.grant_id !== 2'd0) begin
            n_bad++; $display("FAIL reset_regrant: tx_en=%b gid=%0d, want 001/0", ia.src_tx_en, ia.grant_id);
        end
        last_a = 0;
        finish_frame(0, 2, 1'b0);
        ia.src_tx_rdy = '0;
    endtask

    task automatic test_gap0();
        ib.src_tx_rdy = 3'b100;
        step();
        n_cmp++;
        if (ib.src_tx_en !== 3'b100 || ib.grant_id !== 2'd2) begin
            n_bad++; $display("FAIL gap0_grant: tx_en=%b gid=%0d, want 100/2", ib.src_tx_en, ib.grant_id);
        end
        ib.src_tx_rdy = 3'b000;
        step();
        ib.src_d[23:16] = 8'h5C;
        ib.src_d_rdy[2] = 1'b1;
        #1;
        n_cmp++;
        if (ib.busy !== 1'b1 || ib.frame_done !== 1'b0 || ib.ser_d !== 8'h5C || ib.ser_d_rdy !== 1'b1) begin
            n_bad++; $display("FAIL gap0_active: busy=%b fd=%b ser_d=%h rdy=%b, want 1/0/5c/1", ib.busy, ib.frame_done, ib.ser_d, ib.ser_d_rdy);
        end
        step();
        n_cmp++;
        if (ib.frame_done !== 1'b1 || ib.busy !== 1'b0 || ib.ser_d_rdy !== 1'b0) begin
            n_bad++; $display("FAIL gap0_done: fd=%b busy=%b rdy=%b, want 1/0/0", ib.frame_done, ib.busy, ib.ser_d_rdy);
        end
        ib.src_tx_rdy = 3'b001;
        step();
        n_cmp++;
        if (ib.src_tx_en !== 3'b001 || ib.grant_id !== 2'd0) begin
            n_bad++; $display("FAIL gap0_next: tx_en=%b gid=%0d, want 001/0", ib.src_tx_en, ib.grant_id);
        end
        ib.src_tx_rdy = 3'b000;
        step();
        step();
        n_cmp++;
        if (ib.frame_done !== 1'b1 || ib.busy !== 1'b0) begin
            n_bad++; $display("FAIL gap0_done2: fd=%b busy=%b, want 1/0", ib.frame_done, ib.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_isolation();
        test_watchdog();
        test_reset_mid();
        test_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule
